// File: rtl/booth_seq_ctrl.sv
// ---------------------------------------------------------------------------
// booth_seq_ctrl
//
// Sequencer for an external multi-cycle multiplier. An operand pair is
// accepted from upstream, the multiplier is cleared, loaded for LOAD_CYCLES
// cycles, run for RUN_CYCLES cycles, and its product is captured into an
// output register that is held until downstream consumes it.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both high. valid must not depend on ready. Once
// out_valid is high, out_prod and out_valid stay unchanged until the edge
// that consumes them. in_valid while in_ready is low is ignored.
//
// Ports
//   clk          : single clock, rising-edge active
//   rst          : asynchronous, active-low reset
//   in_valid     : upstream presents in_a/in_b
//   in_ready     : operand pair accepted this cycle (combinational)
//   in_a, in_b   : signed operands, WIDTH bits each
//   mul_clr      : clear pulse to the multiplier (CLEAR state)
//   mul_en       : multiplier enable (LOAD and RUN states)
//   mul_load     : operand-load strobe (LOAD state)
//   mul_a, mul_b : latched operands driven to the multiplier
//   mul_product  : signed 2*WIDTH product from the multiplier
//   out_valid    : out_prod holds a completed product
//   out_ready    : downstream consumes out_prod
//   out_prod     : captured signed product
//   busy         : high in every state except IDLE
//   ops_done     : products delivered, wraps at 16 bits
//   dbg_state    : current FSM state (IDLE=0 CLEAR=1 LOAD=2 RUN=3 CAPTURE=4)
// ---------------------------------------------------------------------------
module booth_seq_ctrl #(
    parameter int WIDTH       = 32,
    parameter int LOAD_CYCLES = 2,
    parameter int RUN_CYCLES  = 34
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 mul_clr,
    output logic                 mul_en,
    output logic                 mul_load,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 busy,
    output logic [15:0]          ops_done,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RUN     = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    // Counter is preloaded with (duration - 1) and the phase ends when it
    // reads zero, so a phase of N cycles needs no extra compare logic.
    localparam logic [7:0] LOAD_LAST = 8'(LOAD_CYCLES - 1);
    localparam logic [7:0] RUN_LAST  = 8'(RUN_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic [7:0]         cnt;
    logic               cnt_done;
    logic               accept;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;

    // Registered-output next values, decoded from the next state so the
    // outputs line up with the state they describe.
    logic               clr_d;
    logic               load_d;
    logic               en_d;
    logic               busy_d;

    assign cnt_done  = (cnt == 8'd0);
    assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_a     = op_a;
    assign mul_b     = op_b;
    assign dbg_state = state;

    // -------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (accept)   state_next = ST_CLEAR;
            ST_CLEAR:                 state_next = ST_LOAD;
            ST_LOAD:    if (cnt_done) state_next = ST_RUN;
            ST_RUN:     if (cnt_done) state_next = ST_CAPTURE;
            ST_CAPTURE:               state_next = ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------
    // Output decode (feeds the output registers)
    // -------------------------------------------------------------------
    always_comb begin
        clr_d  = 1'b0;
        load_d = 1'b0;
        en_d   = 1'b0;
        busy_d = 1'b1;
        case (state_next)
            ST_IDLE:    busy_d = 1'b0;
            ST_CLEAR:   clr_d  = 1'b1;
            ST_LOAD: begin
                load_d = 1'b1;
                en_d   = 1'b1;
            end
            ST_RUN:     en_d   = 1'b1;
            ST_CAPTURE: en_d   = 1'b0;
            default:    busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_clr  <= 1'b0;
            mul_load <= 1'b0;
            mul_en   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            mul_clr  <= clr_d;
            mul_load <= load_d;
            mul_en   <= en_d;
            busy     <= busy_d;
        end
    end

    // -------------------------------------------------------------------
    // Phase counter: loaded on CLEAR for LOAD, reloaded at the end of LOAD
    // for RUN, otherwise counts down to zero and rests there.
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 8'd0;
        end else if (state == ST_CLEAR) begin
            cnt <= LOAD_LAST;
        end else if (state == ST_LOAD && cnt_done) begin
            cnt <= RUN_LAST;
        end else if (!cnt_done) begin
            cnt <= cnt - 8'd1;
        end
    end

    // -------------------------------------------------------------------
    // Operand registers: written only on an accepted transfer, so they
    // stay stable for the whole operation regardless of in_valid activity.
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a <= '0;
            op_b <= '0;
        end else if (accept) begin
            op_a <= in_a;
            op_b <= in_b;
        end
    end

    // -------------------------------------------------------------------
    // Result register and delivery counter. CAPTURE setting out_valid has
    // priority over a consume on the same edge.
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_prod  <= '0;
            ops_done  <= 16'd0;
        end else if (state == ST_CAPTURE) begin
            out_valid <= 1'b1;
            out_prod  <= mul_product;
            ops_done  <= ops_done + 16'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/booth_seq_ctrl.md
BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter LOAD_CYCLES, default 2, number of cycles mul_load is held high (range 1..15).
REQ-003 Parameter RUN_CYCLES, default 34, number of cycles the multiplier runs after load (range 1..255).
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port in_valid  input  1  upstream presents an operand pair.
REQ-007 Port in_ready  output  1  block accepts an operand pair this cycle.
REQ-008 Port in_a, in_b  input  WIDTH each  signed operands.
REQ-009 Port mul_clr  output  1  active-high clear pulse to the multiplier.
REQ-010 Port mul_en  output  1  multiplier enable.
REQ-011 Port mul_load  output  1  multiplier operand-load strobe.
REQ-012 Port mul_a, mul_b  output  WIDTH each  operands driven to the multiplier.
REQ-013 Port mul_product  input  2*WIDTH  signed product from the multiplier.
REQ-014 Port out_valid  output  1  out_prod holds a completed product.
REQ-015 Port out_ready  input  1  downstream consumes out_prod.
REQ-016 Port out_prod  output  2*WIDTH  captured signed product.
REQ-017 Port busy  output  1  high in every state except IDLE.
REQ-018 Port ops_done  output  16  count of products delivered; wraps 0xFFFF -> 0x0000.

Function
REQ-019 FSM states: IDLE, CLEAR, LOAD, RUN, CAPTURE; all outputs registered, except in_ready, which is combinational.
REQ-020 in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-021 Accept occurs on an edge where in_valid && in_ready; in_a/in_b are latched into the operand registers and the FSM goes IDLE->CLEAR.
REQ-022 in_valid while in_ready is low is ignored; the operand registers are unchanged.
REQ-023 mul_a/mul_b equal the operand registers and are stable from CLEAR through CAPTURE.
REQ-024 CLEAR lasts exactly 1 cycle: mul_clr=1, mul_en=0, mul_load=0; next state is LOAD.
REQ-025 LOAD lasts exactly LOAD_CYCLES cycles: mul_load=1, mul_en=1; next state is RUN.
REQ-026 RUN lasts exactly RUN_CYCLES cycles: mul_load=0, mul_en=1; driven by an internal down-counter; next state is CAPTURE.
REQ-027 CAPTURE lasts 1 cycle with mul_en=0; at its end, out_prod<=mul_product, out_valid<=1, ops_done increments, and the FSM returns to IDLE.
REQ-028 Latency: if accepted at cycle T, CLEAR is at T+1 and out_valid first goes high at cycle T+3+LOAD_CYCLES+RUN_CYCLES (T+39 at defaults).
REQ-029 out_valid stays high and out_prod stays stable until an edge with out_ready=1; out_valid then clears unless CAPTURE sets it on the same edge.
REQ-030 out_valid && out_ready in IDLE, together with a new accept, is legal: the old result is consumed and the new operation starts on the same edge.
REQ-031 mul_product passes through without truncation or sign change; at WIDTH=32, (-2^31)*(-2^31)=2^62 is captured exactly.
REQ-032 mul_clr, mul_load and mul_en are never high in IDLE.

Reset
REQ-033 While rst=0 (and at any time, including mid-LOAD/RUN): state=IDLE, counters=0, operand regs=0, out_prod=0, ops_done=0, and every registered output (out_valid, busy, mul_clr, mul_en, mul_load, mul_a, mul_b) = 0.
REQ-034 A reset mid-operation discards the operation; no out_valid pulse follows, and the first operation after release starts with a CLEAR cycle.
REQ-035 in_ready may be high in the first cycle after reset release.

Verification (bench uses a behavioural multiplier model that presents a*b on mul_product after the load phase)
REQ-036 Accept a=12, b=-32 with out_ready=1 -> out_valid at T+39, out_prod=-384, ops_done=1, busy low again at T+39.
REQ-037 Operands 13/20, then -51/-4, back to back with in_valid and out_ready tied high -> outputs 260 then 204; second accept on the edge the first result is consumed; no idle gap.
REQ-038 out_ready low for 10 cycles after a 5*15 result -> out_prod=75 held, out_valid held, in_ready=0; then out_ready=1 -> out_valid drops next edge.
REQ-039 rst=0 for 1 cycle during RUN (cycle 20 of 34) -> all outputs 0 immediately, no result delivered; the next op 1*12 -> 12.
REQ-040 in_valid toggling with junk operands while busy -> mul_a/mul_b unchanged, result unaffected.
REQ-041 -2^31 * -2^31 -> out_prod=0x4000_0000_0000_0000; ops_done preloaded to 0xFFFF (via 65535 ops) wraps to 0.
